// File: rtl/p_ssync_nch_edge.sv
// Multi-channel level synchronizer with registered level, rise/fall pulses and change flag.
// Optional per-channel persistence filter enabled by defining P_SSYNC_NCH_FILT_EN.
// Channels are independent; no coherency across bits (not for buses or counters).
module p_ssync_nch_edge #(
    parameter int unsigned     WIDTH    = 4,
    parameter int unsigned     STAGES   = 2,
    parameter int unsigned     FILT_CYC = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             chg
);

    // Reject unsupported synchronizer depths at elaboration
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("p_ssync_nch_edge: STAGES must be 2..4");
    end

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_chg;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Synchronizer chain; only stage 0 may go metastable and only stage 1 samples it
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_sync[k] <= RST_VAL;
            end
        end else begin
            r_sync[0] <= d;
            for (int unsigned k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[STAGES-1];

`ifdef P_SSYNC_NCH_FILT_EN
    localparam int unsigned CNT_W = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    // Reject unsupported filter lengths at elaboration
    if (FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_filt
        $error("p_ssync_nch_edge: FILT_CYC must be 1..15");
    end

    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Accept a new level only after it has persisted FILT_CYC consecutive cycles
    always_comb begin
        w_q_nxt = r_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_q[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_q_nxt[i] = w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Persistence counters
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end
`else
    // Unfiltered: the synchronized level is taken directly; filter length has no effect
    if (FILT_CYC == 0) begin : g_filt_unused
    end

    assign w_q_nxt = w_s;
`endif

    assign w_rise = w_q_nxt & ~r_q;
    assign w_fall = ~w_q_nxt & r_q;

    // Output level, edge pulses aligned with the new level, and aggregate change flag
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_q    <= RST_VAL;
            r_rise <= '0;
            r_fall <= '0;
            r_chg  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_chg  <= |(w_rise | w_fall);
        end
    end

    assign q      = r_q;
    assign q_rise = r_rise;
    assign q_fall = r_fall;
    assign chg    = r_chg;

endmodule

// File: tb/tb_p_ssync_nch_edge.sv
// Self-checking bench for p_ssync_nch_edge: three instances (STAGES 2/3/4) against a
// history-window reference model, plus directed literal expectations.
module tb_p_ssync_nch_edge;

`ifdef P_SSYNC_NCH_FILT_EN
    localparam int F = 3;
`else
    localparam int F = 1;
`endif
    localparam int MAXH = 4 + 15;
    localparam int          STG [3] = '{2, 3, 4};
    localparam logic [3:0]  RV  [3] = '{4'b1010, 4'b0000, 4'b0000};

    logic       clk;
    logic       clr_;
    logic [3:0] d;
    logic [3:0] q2, r2, f2, q3, r3, f3, q4, r4, f4;
    logic       c2, c3, c4;

    int  n_pass;
    int  n_total;
    bit  chk_en;

    // model state
    logic [3:0] hist [3][MAXH];
    logic [3:0] mq [3];
    logic [3:0] mr [3];
    logic [3:0] mf [3];
    logic       mc [3];

    p_ssync_nch_edge #(.WIDTH(4), .STAGES(2), .FILT_CYC(3), .RST_VAL(4'b1010)) u_dut2 (
        .clk(clk), .clr_(clr_), .d(d), .q(q2), .q_rise(r2), .q_fall(f2), .chg(c2));
    p_ssync_nch_edge #(.WIDTH(4), .STAGES(3), .FILT_CYC(3), .RST_VAL(4'b0000)) u_dut3 (
        .clk(clk), .clr_(clr_), .d(d), .q(q3), .q_rise(r3), .q_fall(f3), .chg(c3));
    p_ssync_nch_edge #(.WIDTH(4), .STAGES(4), .FILT_CYC(3), .RST_VAL(4'b0000)) u_dut4 (
        .clk(clk), .clr_(clr_), .d(d), .q(q4), .q_rise(r4), .q_fall(f4), .chg(c4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_inst(input int n, input logic [3:0] qa, input logic [3:0] ra,
                            input logic [3:0] fa, input logic ca);
        chk($sformatf("q[S%0d]", STG[n]), 32'(qa), 32'(mq[n]));
        chk($sformatf("q_rise[S%0d]", STG[n]), 32'(ra), 32'(mr[n]));
        chk($sformatf("q_fall[S%0d]", STG[n]), 32'(fa), 32'(mf[n]));
        chk($sformatf("chg[S%0d]", STG[n]), 32'(ca), 32'(mc[n]));
        chk($sformatf("rise_and_fall[S%0d]", STG[n]), 32'(ra & fa), 32'd0);
    endtask

    // Reference model: q toggles when the last F synchronized samples all differ from q;
    // the synchronized sample seen at edge k is d as sampled at edge k-STAGES.
    initial begin
        forever begin
            @(posedge clk or negedge clr_);
            if (!clr_) begin
                for (int n = 0; n < 3; n++) begin
                    for (int j = 0; j < MAXH; j++) hist[n][j] = RV[n];
                    mq[n] = RV[n];
                    mr[n] = 4'b0;
                    mf[n] = 4'b0;
                    mc[n] = 1'b0;
                end
            end else begin
                for (int n = 0; n < 3; n++) begin
                    logic [3:0] nq;
                    for (int j = MAXH - 1; j > 0; j--) hist[n][j] = hist[n][j-1];
                    hist[n][0] = d;
                    nq = mq[n];
                    for (int i = 0; i < 4; i++) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        for (int j = STG[n]; j < STG[n] + F; j++)
                            if (hist[n][j][i] == mq[n][i]) all_diff = 1'b0;
                        if (all_diff) nq[i] = ~mq[n][i];
                    end
                    mr[n] = nq & ~mq[n];
                    mf[n] = ~nq & mq[n];
                    mc[n] = |(mr[n] | mf[n]);
                    mq[n] = nq;
                end
            end
        end
    end

    // Compare process: every falling edge once checking is enabled
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk_inst(0, q2, r2, f2, c2);
                chk_inst(1, q3, r3, f3, c3);
                chk_inst(2, q4, r4, f4, c4);
            end
        end
    end

    // Expected q[1] for a high pulse of length len starting at edge N, k edges later (S=2)
    function automatic logic exp_pulse_q(input int k, input int len);
        if (len < F) return 1'b0;
        return (k >= 2 + F - 1) && (k <= 2 + F - 1 + len - 1);
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        chk_en  = 1'b0;
        clr_    = 1'b1;
        d       = 4'b0000;

        // 1. Asynchronous reset, no clock edge
        #2 clr_ = 1'b0;
        #1;
        chk("rst_q2", 32'(q2), 32'h0000000a);
        chk("rst_rise2", 32'(r2), 32'h0);
        chk("rst_fall2", 32'(f2), 32'h0);
        chk("rst_chg2", 32'(c2), 32'h0);
        chk("rst_q3", 32'(q3), 32'h0);
        chk("rst_q4", 32'(q4), 32'h0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        clr_ = 1'b1;
        repeat (10) @(negedge clk);

        // 2. Latency per depth on channel 0
        d = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat_q0_S2_k%0d", k), 32'(q2[0]), 32'(k >= 2 + F - 1));
            chk($sformatf("lat_rise0_S2_k%0d", k), 32'(r2[0]), 32'(k == 2 + F - 1));
            chk($sformatf("lat_q0_S3_k%0d", k), 32'(q3[0]), 32'(k >= 3 + F - 1));
            chk($sformatf("lat_rise0_S3_k%0d", k), 32'(r3[0]), 32'(k == 3 + F - 1));
            chk($sformatf("lat_q0_S4_k%0d", k), 32'(q4[0]), 32'(k >= 4 + F - 1));
            chk($sformatf("lat_rise0_S4_k%0d", k), 32'(r4[0]), 32'(k == 4 + F - 1));
        end

        // 3. Simultaneous rise and fall on different channels
        d = 4'b0011;
        repeat (10) @(negedge clk);
        d = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2 + F - 1) begin
                chk("multi_rise", 32'(r2), 32'h4);
                chk("multi_fall", 32'(f2), 32'h2);
                chk("multi_chg", 32'(c2), 32'h1);
                chk("multi_q", 32'(q2), 32'h5);
            end
            if (k == 2 + F) chk("multi_chg_next", 32'(c2), 32'h0);
        end

        // 4. Short and persistent highs on channel 1
        for (int len = 2; len <= 3; len++) begin
            d = 4'b0000;
            repeat (10) @(negedge clk);
            d = 4'b0010;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (k == len - 1) d = 4'b0000;
                chk($sformatf("filt_len%0d_q1_k%0d", len, k), 32'(q2[1]), 32'(exp_pulse_q(k, len)));
                chk($sformatf("filt_len%0d_rise1_k%0d", len, k), 32'(r2[1]),
                    32'(exp_pulse_q(k, len) && !exp_pulse_q(k - 1, len)));
            end
        end

        // 5. Reset mid-operation while a pulse is high
        d = 4'b0000;
        repeat (10) @(negedge clk);
        d = 4'b1111;
        repeat (2 + F - 1) @(negedge clk);
        @(posedge clk);
        #2 clr_ = 1'b0;
        #1;
        chk("midrst_q2", 32'(q2), 32'h0000000a);
        chk("midrst_rise2", 32'(r2), 32'h0);
        chk("midrst_fall2", 32'(f2), 32'h0);
        chk("midrst_chg2", 32'(c2), 32'h0);
        chk("midrst_q3", 32'(q3), 32'h0);
        chk("midrst_rise3", 32'(r3), 32'h0);
        chk("midrst_q4", 32'(q4), 32'h0);
        @(negedge clk);
        clr_ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2 + F - 1) chk("rel_rise2", 32'(r2), 32'h5);
            if (k == 3 + F - 1) chk("rel_rise3", 32'(r3), 32'hf);
            if (k == 4 + F - 1) chk("rel_rise4", 32'(r4), 32'hf);
            if (k == 4 + F) chk("rel_rise4_next", 32'(r4), 32'h0);
        end

        // 6. Randomized stimulus in phases: fully random, sparse toggles, short bursts
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            case ((c / 500) % 3)
                0: d = 4'($urandom);
                1: if ($urandom_range(0, 5) == 0) d = d ^ (4'b0001 << $urandom_range(0, 3));
                default: if ($urandom_range(0, 2) == 0) d = 4'($urandom);
            endcase
            if (c == 9001) begin
                #2 clr_ = 1'b0;
                @(negedge clk);
                clr_ = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
